// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
// The digit count and counter width are derived here so the top and the bench agree on them.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int calc_ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // A single-digit configuration still needs a 1-bit counter.
  function automatic int calc_cnt_w(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder. It is purely combinational, with no handshake and no state.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Digit-serial adder: a + b + cin over WIDTH/DIGIT cycles, LSB digit first, valid/ready on both sides.
// Result is held in DONE until out_ready; in_ready only in IDLE, so no overlap between operations.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NDIG  = calc_ndig(WIDTH, DIGIT);
  localparam int CNT_W = calc_cnt_w(NDIG);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

  generate
    if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("serial_add_ctrl: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [DIGIT:0]    chain_c;
  logic [DIGIT-1:0]  digit_s;
  logic [WIDTH-1:0]  sum_shift;

  assign chain_c[0] = carry_q;

  generate
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
      fa_cell u_fa (
        .a  (a_q[gi]),
        .b  (b_q[gi]),
        .ci (chain_c[gi]),
        .s  (digit_s[gi]),
        .co (chain_c[gi+1])
      );
    end
  endgenerate

  // New digit enters at the MSB end; after NDIG shifts the first digit lands at bit 0.
  generate
    if (WIDTH > DIGIT) begin : g_shift_wide
      assign sum_shift = {digit_s, sum_q[WIDTH-1:DIGIT]};
    end else begin : g_shift_single
      assign sum_shift = digit_s;
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        sum_d   = sum_shift;
        carry_d = chain_c[DIGIT];
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  // The carry register is frozen outside RUN, so it doubles as the held carry-out.
  assign sum  = sum_q;
  assign cout = carry_q;

endmodule
